sobel_thresh_ctrl: RTL and testbench

Frame-synchronous threshold controller for the Sobel edge-detection stage. It observes the binary Sobel output stream and counts edge pixels (value 0) in each frame, excluding a border region. During vertical blanking it computes the next frame's threshold, either adaptively toward a target edge count or from a manual value. Its `threshold` output drives the Sobel stage's threshold input, which guarantees the threshold never changes inside an active frame.

---
 rtl/sobel_thresh_ctrl_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 23 ++
 rtl/sobel_thresh_ctrl.sv | 147 ++++++++++++++
 tb/tb_sobel_thresh_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_thresh_ctrl_pkg.sv
// Shared widths, reset defaults and FSM state type for the Sobel threshold controller.
package sobel_thresh_ctrl_pkg;

  localparam int unsigned PIX_CNT_W_DEF = 20;
  localparam int unsigned BORDER_DEF    = 2;
  localparam int unsigned LINE_CNT_W    = 16;
  localparam logic [7:0]  TH_INIT_DEF   = 8'd60;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    ACTIVE,
    UPDATE
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Registers a sync strobe and flags its rising and falling edges in the current cycle.
module sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sig,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise_c = i_sig & ~r_prev;
  assign o_fall_c = ~i_sig & r_prev;

endmodule

// File: rtl/sobel_thresh_ctrl.sv
// Counts edge pixels per frame outside the border and retunes the Sobel threshold
// once per vertical blanking, either toward a target edge count or from a manual value.
module sobel_thresh_ctrl
  import sobel_thresh_ctrl_pkg::*;
#(
  parameter int unsigned PIX_CNT_W = PIX_CNT_W_DEF,
  parameter logic [7:0]  TH_INIT   = TH_INIT_DEF,
  parameter int unsigned BORDER    = BORDER_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sobel,
  input  logic                 sobel_valid,
  input  logic                 sobel_hsync,
  input  logic                 sobel_vsync,
  input  logic                 auto_en,
  input  logic [7:0]           threshold_manual,
  input  logic [PIX_CNT_W-1:0] target_edges,
  input  logic [PIX_CNT_W-1:0] hyst,
  input  logic [3:0]           step,
  input  logic [7:0]           th_min,
  input  logic [7:0]           th_max,
  output logic [7:0]           threshold,
  output logic [PIX_CNT_W-1:0] frame_edges,
  output logic                 frame_done,
  output logic                 cfg_err
);

  state_e                r_state;
  logic [PIX_CNT_W-1:0]  r_edge_cnt;
  logic [PIX_CNT_W-1:0]  r_frame_edges;
  logic [LINE_CNT_W-1:0] r_col;
  logic [LINE_CNT_W-1:0] r_row;
  logic [7:0]            r_threshold;
  logic                  r_frame_done;
  logic                  r_cfg_err;

  logic                  w_vs_rise;
  logic                  w_vs_fall;
  logic                  w_hs_rise_unused;
  logic                  w_hs_fall;
  logic                  w_count;

  logic [PIX_CNT_W:0]    w_hi;
  logic [PIX_CNT_W-1:0]  w_lo;
  logic [8:0]            w_sum;
  logic [7:0]            w_diff;
  logic [7:0]            w_up;
  logic [7:0]            w_dn;
  logic [7:0]            w_th_next;
  logic                  w_cfg_bad;

  sync_edge_det u_vs_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_sig    (sobel_vsync),
    .o_rise_c (w_vs_rise),
    .o_fall_c (w_vs_fall)
  );

  sync_edge_det u_hs_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_sig    (sobel_hsync),
    .o_rise_c (w_hs_rise_unused),
    .o_fall_c (w_hs_fall)
  );

  assign w_count = (r_state == ACTIVE) && sobel_vsync && sobel_valid && !sobel &&
                   (r_col >= LINE_CNT_W'(BORDER)) && (r_row >= LINE_CNT_W'(BORDER));

  // Next threshold from the last frame's edge count; only consumed in UPDATE.
  always_comb begin
    w_hi      = {1'b0, target_edges} + {1'b0, hyst};
    w_lo      = (target_edges > hyst) ? (target_edges - hyst) : '0;
    w_sum     = {1'b0, r_threshold} + 9'(step);
    w_diff    = (r_threshold > 8'(step)) ? (r_threshold - 8'(step)) : '0;
    w_up      = (w_sum > {1'b0, th_max}) ? th_max : w_sum[7:0];
    w_dn      = (w_diff < th_min) ? th_min : w_diff;
    w_cfg_bad = th_min > th_max;
    w_th_next = r_threshold;
    if (!auto_en) begin
      w_th_next = threshold_manual;
    end else if (w_cfg_bad) begin
      w_th_next = r_threshold;
    end else if ({1'b0, r_frame_edges} > w_hi) begin
      w_th_next = w_up;
    end else if (r_frame_edges < w_lo) begin
      w_th_next = w_dn;
    end
  end

  // Frame FSM with pixel/line counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= SYNC;
      r_edge_cnt    <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_threshold   <= TH_INIT;
      r_frame_edges <= '0;
      r_frame_done  <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        SYNC: begin
          if (!sobel_vsync) r_state <= IDLE;
        end
        IDLE: begin
          r_edge_cnt <= '0;
          r_col      <= '0;
          r_row      <= '0;
          if (w_vs_rise) r_state <= ACTIVE;
        end
        ACTIVE: begin
          // ACTIVE is held only while vsync stays high, so its fall is the first low sample.
          if (w_vs_fall) begin
            r_frame_edges <= r_edge_cnt;
            r_state       <= UPDATE;
          end else begin
            if (w_hs_fall) begin
              r_col <= '0;
              if (r_row != '1) r_row <= r_row + LINE_CNT_W'(1);
            end else if (sobel_valid && (r_col != '1)) begin
              r_col <= r_col + LINE_CNT_W'(1);
            end
            if (w_count && (r_edge_cnt != '1)) r_edge_cnt <= r_edge_cnt + PIX_CNT_W'(1);
          end
        end
        UPDATE: begin
          r_threshold  <= w_th_next;
          r_cfg_err    <= w_cfg_bad;
          r_frame_done <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  assign threshold   = r_threshold;
  assign frame_edges = r_frame_edges;
  assign frame_done  = r_frame_done;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_sobel_thresh_ctrl.sv
// Self-checking bench for sobel_thresh_ctrl: directed table, hand-written reset/manual
// sequences, and randomized frames against an arithmetic reference model.
module tb_sobel_thresh_ctrl;

  localparam int unsigned W = 20;

  logic         clk;
  logic         reset_n;
  logic         sobel;
  logic         sobel_valid;
  logic         sobel_hsync;
  logic         sobel_vsync;
  logic         auto_en;
  logic [7:0]   threshold_manual;
  logic [W-1:0] target_edges;
  logic [W-1:0] hyst;
  logic [3:0]   step;
  logic [7:0]   th_min;
  logic [7:0]   th_max;
  logic [7:0]   threshold;
  logic [W-1:0] frame_edges;
  logic         frame_done;
  logic         cfg_err;

  int n_cmp;
  int n_fail;
  bit pix [0:7][0:15];

  typedef struct {
    bit a;
    int man;
    int tgt;
    int hy;
    int st;
    int mn;
    int mx;
    bit white;
    int exp_edges;
    int exp_th;
    bit exp_cfg;
  } vec_t;

  vec_t tbl [18];

  sobel_thresh_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sobel            (sobel),
    .sobel_valid      (sobel_valid),
    .sobel_hsync      (sobel_hsync),
    .sobel_vsync      (sobel_vsync),
    .auto_en          (auto_en),
    .threshold_manual (threshold_manual),
    .target_edges     (target_edges),
    .hyst             (hyst),
    .step             (step),
    .th_min           (th_min),
    .th_max           (th_max),
    .threshold        (threshold),
    .frame_edges      (frame_edges),
    .frame_done       (frame_done),
    .cfg_err          (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit a, input int man, input int tgt, input int hy,
                              input int st, input int mn, input int mx, input bit white,
                              input int ee, input int et, input bit ec);
    vec_t v;
    v.a = a; v.man = man; v.tgt = tgt; v.hy = hy; v.st = st; v.mn = mn; v.mx = mx;
    v.white = white; v.exp_edges = ee; v.exp_th = et; v.exp_cfg = ec;
    return v;
  endfunction

  task automatic set_cfg(input bit a, input int man, input int tgt, input int hy,
                         input int st, input int mn, input int mx);
    auto_en          = a;
    threshold_manual = 8'(man);
    target_edges     = W'(tgt);
    hyst             = W'(hy);
    step             = 4'(st);
    th_min           = 8'(mn);
    th_max           = 8'(mx);
  endtask

  // mode 0: all edges, 1: all non-edges, 2: random density
  task automatic fill(input int mode);
    int p;
    p = $urandom_range(0, 4);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++)
        if (mode == 0) pix[r][c] = 1'b0;
        else if (mode == 1) pix[r][c] = 1'b1;
        else pix[r][c] = !($urandom_range(0, 3) < p);
  endtask

  function automatic int count_edges(input int rows, input int cols);
    int n;
    n = 0;
    for (int r = 2; r < rows; r++)
      for (int c = 2; c < cols; c++)
        if (pix[r][c] == 1'b0) n++;
    return n;
  endfunction

  function automatic int model_th(input int th, input int edges, input bit a, input int man,
                                  input int tgt, input int hy, input int st, input int mn,
                                  input int mx);
    int hi;
    int lo;
    int d;
    if (!a) return man;
    if (mn > mx) return th;
    hi = tgt + hy;
    lo = (tgt - hy < 0) ? 0 : tgt - hy;
    if (edges > hi) return (th + st > mx) ? mx : th + st;
    if (edges < lo) begin
      d = (th - st < 0) ? 0 : th - st;
      return (d < mn) ? mn : d;
    end
    return th;
  endfunction

  // Drives one frame; returns just after vsync has been dropped (not yet sampled).
  task automatic drive_frame(input int rows, input int cols, input bit gaps, input int mid_man);
    sobel_vsync = 1'b1;
    sobel_valid = 1'b0;
    cyc();
    cyc();
    for (int r = 0; r < rows; r++) begin
      if (r == 1 && mid_man >= 0) threshold_manual = 8'(mid_man);
      sobel_hsync = 1'b1;
      for (int c = 0; c < cols; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          sobel_valid = 1'b0;
          sobel       = 1'($urandom);
          cyc();
        end
        sobel_valid = 1'b1;
        sobel       = pix[r][c];
        cyc();
      end
      sobel_valid = 1'b0;
      sobel_hsync = 1'b0;
      cyc();
      cyc();
    end
    sobel_vsync = 1'b0;
    sobel_valid = 1'b1;
    sobel       = 1'b0;
  endtask

  task automatic check_update(input string tag, input int exp_edges, input int old_th,
                              input int exp_th, input bit exp_cfg);
    cyc();
    chk({tag, "_edges"}, int'(frame_edges), exp_edges);
    chk({tag, "_th_k"}, int'(threshold), old_th);
    chk({tag, "_done_k"}, int'(frame_done), 0);
    cyc();
    chk({tag, "_th"}, int'(threshold), exp_th);
    chk({tag, "_done"}, int'(frame_done), 1);
    chk({tag, "_cfg"}, int'(cfg_err), int'(exp_cfg));
    cyc();
    chk({tag, "_done_off"}, int'(frame_done), 0);
    sobel_valid = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask

  initial begin
    int cur;
    int done_cnt;
    n_cmp  = 0;
    n_fail = 0;

    tbl[0]  = mk(1'b0,  60,  0, 0,  0,  0, 255, 1'b1,  0,  60, 1'b0);
    tbl[1]  = mk(1'b1,   0,  4, 1,  5,  0, 255, 1'b0, 12,  65, 1'b0);
    tbl[2]  = mk(1'b0,  60,  0, 0,  0,  0, 255, 1'b1,  0,  60, 1'b0);
    tbl[3]  = mk(1'b1,   0,  4, 1,  5, 50, 255, 1'b1,  0,  55, 1'b0);
    tbl[4]  = mk(1'b1,   0,  4, 1,  5, 50, 255, 1'b1,  0,  50, 1'b0);
    tbl[5]  = mk(1'b1,   0,  4, 1,  5, 50, 255, 1'b1,  0,  50, 1'b0);
    tbl[6]  = mk(1'b0,  60,  0, 0,  0,  0, 255, 1'b1,  0,  60, 1'b0);
    tbl[7]  = mk(1'b1,   0,  4, 1,  5,  0,  62, 1'b0, 12,  62, 1'b0);
    tbl[8]  = mk(1'b1,   0,  4, 1,  5, 70,  60, 1'b0, 12,  62, 1'b1);
    tbl[9]  = mk(1'b1,   0,  4, 1,  5,  0, 255, 1'b1,  0,  57, 1'b0);
    tbl[10] = mk(1'b1,   0, 12, 0,  5,  0, 255, 1'b0, 12,  57, 1'b0);
    tbl[11] = mk(1'b1,   0, 13, 1,  5,  0, 255, 1'b0, 12,  57, 1'b0);
    tbl[12] = mk(1'b1,   0, 14, 1,  5,  0, 255, 1'b0, 12,  52, 1'b0);
    tbl[13] = mk(1'b1,   0,  2, 5,  5,  0, 255, 1'b1,  0,  52, 1'b0);
    tbl[14] = mk(1'b0, 250,  0, 0,  0,  0, 255, 1'b1,  0, 250, 1'b0);
    tbl[15] = mk(1'b1,   0,  0, 0, 15,  0, 255, 1'b0, 12, 255, 1'b0);
    tbl[16] = mk(1'b0,   3,  0, 0,  0,  0, 255, 1'b1,  0,   3, 1'b0);
    tbl[17] = mk(1'b1,   0,  4, 1, 15,  0, 255, 1'b1,  0,   0, 1'b0);

    // Reset values
    reset_n     = 1'b0;
    sobel       = 1'b1;
    sobel_valid = 1'b0;
    sobel_hsync = 1'b0;
    sobel_vsync = 1'b0;
    set_cfg(1'b1, 0, 4, 1, 5, 0, 255);
    repeat (3) cyc();
    chk("rst_threshold", int'(threshold), 60);
    chk("rst_frame_edges", int'(frame_edges), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    reset_n = 1'b1;
    cyc();
    cyc();

    // Manual value changed mid-frame only lands at the update
    set_cfg(1'b0, 60, 4, 1, 5, 0, 255);
    fill(0);
    drive_frame(4, 8, 1'b0, 100);
    chk("man_hold_mid", int'(threshold), 60);
    check_update("manual", 12, 60, 100, 1'b0);

    // Directed table
    cur = 100;
    for (int i = 0; i < 18; i++) begin
      set_cfg(tbl[i].a, tbl[i].man, tbl[i].tgt, tbl[i].hy, tbl[i].st, tbl[i].mn, tbl[i].mx);
      fill(tbl[i].white ? 1 : 0);
      drive_frame(4, 8, 1'(i % 2), -1);
      check_update($sformatf("vec%0d", i), tbl[i].exp_edges, cur, tbl[i].exp_th,
                   tbl[i].exp_cfg);
      cur = tbl[i].exp_th;
    end

    // Reset pulsed in the middle of a frame discards it
    set_cfg(1'b1, 0, 4, 1, 5, 0, 255);
    fill(0);
    sobel_vsync = 1'b1;
    sobel_valid = 1'b0;
    cyc();
    cyc();
    sobel_hsync = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sobel_valid = 1'b1;
      sobel       = 1'b0;
      cyc();
    end
    reset_n = 1'b0;
    cyc();
    chk("rstmid_threshold", int'(threshold), 60);
    chk("rstmid_frame_edges", int'(frame_edges), 0);
    chk("rstmid_frame_done", int'(frame_done), 0);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) cyc();
    for (int r = 1; r < 4; r++) begin
      sobel_valid = 1'b0;
      sobel_hsync = 1'b0;
      cyc();
      cyc();
      sobel_hsync = 1'b1;
      sobel_valid = 1'b1;
      for (int c = 0; c < 8; c++) cyc();
    end
    sobel_valid = 1'b0;
    sobel_hsync = 1'b0;
    cyc();
    sobel_vsync = 1'b0;
    done_cnt    = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (frame_done) done_cnt++;
    end
    chk("rstmid_no_done", done_cnt, 0);
    chk("rstmid_th_hold", int'(threshold), 60);
    drive_frame(4, 8, 1'b0, -1);
    check_update("post_rst", 12, 60, 65, 1'b0);

    // Randomized frames against the reference model
    cur = 65;
    for (int f = 0; f < 30; f++) begin
      int rows, cols, tgt, hy, st, mn, mx, man, e, nth;
      bit a;
      rows = $urandom_range(3, 7);
      cols = $urandom_range(3, 12);
      a    = ($urandom_range(0, 3) != 0);
      mn   = $urandom_range(0, 120);
      mx   = $urandom_range(mn, 255);
      if (a && $urandom_range(0, 7) == 0) begin
        mn = $urandom_range(121, 255);
        mx = $urandom_range(0, 120);
      end
      tgt = $urandom_range(0, 40);
      hy  = $urandom_range(0, 8);
      st  = $urandom_range(0, 15);
      man = $urandom_range(0, 255);
      set_cfg(a, man, tgt, hy, st, mn, mx);
      fill(2);
      e   = count_edges(rows, cols);
      nth = model_th(cur, e, a, man, tgt, hy, st, mn, mx);
      drive_frame(rows, cols, 1'b1, -1);
      check_update($sformatf("rnd%0d", f), e, cur, nth, mn > mx);
      cur = nth;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
